// File: rtl/event_replay_driver.sv
// event_replay_driver: replays timestamped records from a record memory into monitor input channels
//   clk, rst         clock, synchronous active-high reset
//   en               global enable; low freezes state and counters and silences strobes
//   start, abort     begin replay from address 0 / return to idle (abort has priority)
//   loop_en          restart from address 0 after the last record instead of finishing
//   rec_addr         record memory read address
//   rec_data         record word {last, delta, mask, values}, sampled one cycle after rec_addr
//   input_val        per-channel values, driven only for masked channels during FIRE
//   new_input        per-channel event strobes
//   busy, done       replay in progress / one-cycle end-of-trace pulse
//   fire_cnt         saturating count of records fired with a non-empty mask
module event_replay_driver #(
    parameter int NUM_IN  = 2,
    parameter int DATA_W  = 64,
    parameter int DELTA_W = 16,
    parameter int DEPTH   = 256,
    parameter int CNT_W   = 16,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int REC_W  = 1 + DELTA_W + NUM_IN + NUM_IN * DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     loop_en,
    output logic [AW-1:0]            rec_addr,
    input  logic [REC_W-1:0]         rec_data,
    output logic [NUM_IN*DATA_W-1:0] input_val,
    output logic [NUM_IN-1:0]        new_input,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         fire_cnt
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, FIRE, GAP, DONE} state_t;
    state_t                    state_q, state_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic [DELTA_W-1:0]        cnt_q, cnt_d;
    logic                      last_q, last_d;
    logic [NUM_IN-1:0]         mask_q, mask_d;
    logic [NUM_IN*DATA_W-1:0]  vals_q, vals_d;
    logic [CNT_W-1:0]          fcnt_q, fcnt_d;
    logic                      rec_last;
    logic [DELTA_W-1:0]        rec_delta;
    logic [NUM_IN-1:0]         rec_mask;
    logic [NUM_IN*DATA_W-1:0]  rec_vals;
    logic [AW-1:0]             addr_inc;
    logic                      ending;
    assign {rec_last, rec_delta, rec_mask, rec_vals} = rec_data;
    assign addr_inc = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
    // In GAP the address was already advanced, so 0 means the fired record sat at DEPTH-1
    assign ending   = last_q || (addr_q == '0);
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        mask_d  = mask_q;
        vals_d  = vals_q;
        fcnt_d  = fcnt_q;
        if (en) begin
            if (abort) begin
                state_d = IDLE;
                addr_d  = '0;
            end else begin
                case (state_q)
                    IDLE, DONE: if (start) begin
                        state_d = FETCH;
                        addr_d  = '0;
                        fcnt_d  = '0;
                    end
                    FETCH: begin
                        {last_d, cnt_d, mask_d, vals_d} = rec_data;
                        state_d = (rec_delta == '0) ? FIRE : WAIT;
                    end
                    WAIT: begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = (cnt_q <= DELTA_W'(1)) ? FIRE : WAIT;
                    end
                    FIRE: begin
                        state_d = GAP;
                        addr_d  = addr_inc;
                        fcnt_d  = (|mask_q && !(&fcnt_q)) ? fcnt_q + 1'b1 : fcnt_q;
                    end
                    GAP: begin
                        {last_d, cnt_d, mask_d, vals_d} = rec_data;
                        state_d = ending ? (loop_en ? FETCH : DONE) : ((rec_delta == '0) ? FIRE : WAIT);
                        addr_d  = ending ? '0 : addr_q;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            mask_q  <= '0;
            vals_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            vals_q  <= vals_d;
            fcnt_q  <= fcnt_d;
        end
    end
    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        assign input_val[i*DATA_W +: DATA_W] = (state_q == FIRE && mask_q[i]) ? vals_q[i*DATA_W +: DATA_W] : '0;
    end
    assign new_input = (en && state_q == FIRE) ? mask_q : '0;
    assign done      = en && !abort && state_q == GAP && ending && !loop_en;
    assign busy      = state_q inside {FETCH, WAIT, FIRE, GAP};
    assign rec_addr  = addr_q;
    assign fire_cnt  = fcnt_q;
endmodule

// File: tb/tb_event_replay_driver.sv
// tb_event_replay_driver: directed checks of event_replay_driver with 2 channels, DEPTH=4, 3-bit fire counter
module tb_event_replay_driver;
    localparam int REC_W = 1 + 4 + 2 + 16;
    logic              clk = 1'b0;
    logic              rst, en, start, abort, loop_en;
    logic [1:0]        rec_addr;
    logic [REC_W-1:0]  rec_data;
    logic [15:0]       input_val;
    logic [1:0]        new_input;
    logic              busy, done;
    logic [2:0]        fire_cnt;
    logic [REC_W-1:0]  mem [4];
    logic [1:0]        ni [32];
    logic [15:0]       iv [32];
    logic              dn [32];
    logic              bz [32];
    logic [2:0]        fc [32];
    logic [1:0]        ad [32];
    int                checks = 0;
    int                errors = 0;

    event_replay_driver #(.NUM_IN(2), .DATA_W(8), .DELTA_W(4), .DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort), .loop_en(loop_en),
        .rec_addr(rec_addr), .rec_data(rec_data), .input_val(input_val), .new_input(new_input),
        .busy(busy), .done(done), .fire_cnt(fire_cnt)
    );

    always #5 clk = ~clk;
    assign rec_data = mem[rec_addr];

    function automatic logic [REC_W-1:0] rec(input logic l, input logic [3:0] d, input logic [1:0] m,
                                             input logic [7:0] v1, input logic [7:0] v0);
        return {l, d, m, v1, v0};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // start is high for the current cycle t; index k holds outputs observed in cycle t+k
    task automatic run(input int n, input logic [31:0] en_off);
        start = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            en = !en_off[k];
            @(negedge clk);
            ni[k] = new_input; iv[k] = input_val; dn[k] = done;
            bz[k] = busy; fc[k] = fire_cnt; ad[k] = rec_addr;
        end
        en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr", rec_addr, 0);
        check("rst_ni", new_input, 0);
        check("rst_iv", input_val, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", fire_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // single delayed record then a zero-delta last record
        mem[0] = rec(0, 3, 2'b01, 0, 1);
        mem[1] = rec(1, 0, 2'b01, 0, 2);
        run(9, 0);
        for (int k = 1; k <= 9; k++) begin
            check($sformatf("t1_ni%0d", k), ni[k], (k == 5 || k == 7) ? 2'b01 : 2'b00);
            check($sformatf("t1_done%0d", k), dn[k], k == 8);
        end
        check("t1_iv5", iv[5], 16'h0001);
        check("t1_iv6", iv[6], 16'h0000);
        check("t1_iv7", iv[7], 16'h0002);
        check("t1_busy1", bz[1], 1);
        check("t1_busy9", bz[9], 0);
        check("t1_cnt", fc[9], 2);

        // zero-delta burst
        mem[0] = rec(0, 0, 2'b01, 0, 3);
        mem[1] = rec(0, 0, 2'b01, 0, 4);
        mem[2] = rec(1, 0, 2'b01, 0, 5);
        run(8, 0);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("t2_ni%0d", k), ni[k], (k == 2 || k == 4 || k == 6) ? 2'b01 : 2'b00);
            if (k < 8) check($sformatf("t2_adj%0d", k), ni[k] & ni[k+1], 0);
        end
        check("t2_clr", fc[1], 0);
        check("t2_cnt3", fc[3], 1);
        check("t2_cnt", fc[8], 3);
        check("t2_done", dn[7], 1);

        // channel mask and an empty-mask delay record
        mem[0] = rec(0, 0, 2'b10, 8'hFB, 8'h07);
        mem[1] = rec(1, 1, 2'b00, 8'h09, 8'h09);
        run(7, 0);
        check("t3_ni2", ni[2], 2'b10);
        check("t3_iv2", iv[2], 16'hFB00);
        check("t3_ni5", ni[5], 2'b00);
        check("t3_iv5", iv[5], 16'h0000);
        check("t3_done", dn[6], 1);
        check("t3_cnt", fc[7], 1);

        // loop mode, then abort together with start
        loop_en = 1'b1;
        mem[0] = rec(0, 1, 2'b01, 0, 1);
        mem[1] = rec(1, 1, 2'b01, 0, 2);
        run(14, 0);
        for (int k = 1; k <= 14; k++) begin
            check($sformatf("t4_ni%0d", k), ni[k], (k == 3 || k == 6 || k == 10 || k == 13) ? 2'b01 : 2'b00);
            check($sformatf("t4_done%0d", k), dn[k], 0);
        end
        check("t4_iv10", iv[10], 16'h0001);
        check("t4_iv13", iv[13], 16'h0002);
        check("t4_addr7", ad[7], 2);
        check("t4_addr8", ad[8], 0);
        check("t4_cnt", fc[14], 4);
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0; loop_en = 1'b0;
        @(negedge clk);
        check("t4_ab_busy", busy, 0);
        check("t4_ab_addr", rec_addr, 0);
        check("t4_ab_cnt", fire_cnt, 4);
        @(negedge clk);
        check("t4_ab_idle", busy, 0);

        // enable stalls in WAIT (cycles 3-6) and in FIRE (cycles 11-12)
        mem[0] = rec(1, 5, 2'b01, 0, 6);
        run(15, 32'h0000_1878);
        for (int k = 1; k <= 15; k++)
            check($sformatf("t5_ni%0d", k), ni[k], (k == 13) ? 2'b01 : 2'b00);
        check("t5_iv11", iv[11], 16'h0006);
        check("t5_cnt12", fc[12], 0);
        check("t5_done", dn[14], 1);
        check("t5_busy", bz[15], 0);

        // end by address wrap without a last bit
        for (int i = 0; i < 4; i++) mem[i] = rec(0, 0, 2'b01, 0, 8'(i + 1));
        run(10, 0);
        for (int k = 1; k <= 10; k++)
            check($sformatf("t6_ni%0d", k), ni[k], (k == 2 || k == 4 || k == 6 || k == 8) ? 2'b01 : 2'b00);
        check("t6_iv8", iv[8], 16'h0004);
        check("t6_done", dn[9], 1);
        check("t6_cnt", fc[10], 4);

        // looping wrap-ended trace saturates the counter, then reset in WAIT
        mem[0] = rec(0, 5, 2'b01, 0, 1);
        loop_en = 1'b1;
        run(31, 0);
        check("t6_sat27", fc[27], 7);
        check("t6_sat", fc[31], 7);
        check("t6_busy31", bz[31], 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; loop_en = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_addr", rec_addr, 0);
        check("t6_rst_cnt", fire_cnt, 0);
        check("t6_rst_ni", new_input, 0);
        check("t6_rst_iv", input_val, 0);
        run(8, 0);
        check("t6_re_ni6", ni[6], 2'b00);
        check("t6_re_ni7", ni[7], 2'b01);
        check("t6_re_iv7", iv[7], 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
